// File: rtl/pi1_pkg.sv
// Shared PerInt master definitions: op codes, FSM state encodings and the command payload.
// The payload struct here is sized for the default 16-bit build; wider builds re-derive it locally.
package pi1_pkg;

  localparam int unsigned PI1_ARCHBITSZ = 16;

  // Address width for a byte-addressed bus of the given data width.
  function automatic int unsigned pi1_addrbitsz(input int unsigned archbitsz);
    return archbitsz - $clog2(archbitsz / 8);
  endfunction

  localparam int unsigned PI1_ADDRBITSZ = pi1_addrbitsz(PI1_ARCHBITSZ);
  localparam int unsigned PI1_SELBITSZ  = PI1_ARCHBITSZ / 8;

  localparam logic [1:0] PINOOP = 2'b00;
  localparam logic [1:0] PIWROP = 2'b01;
  localparam logic [1:0] PIRDOP = 2'b10;
  localparam logic [1:0] PIRWOP = 2'b11;

  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_ISSUE    = 2'd1;
  localparam logic [1:0] ST_WAITDATA = 2'd2;
  localparam logic [1:0] ST_RESP     = 2'd3;

  typedef struct packed {
    logic [1:0]               op;
    logic [PI1_ADDRBITSZ-1:0] addr;
    logic [PI1_ARCHBITSZ-1:0] data;
    logic [PI1_SELBITSZ-1:0]  sel;
  } pi1_cmd_t;

endpackage

// File: rtl/pi1_cmdfifo.sv
// Synchronous first-word-fall-through FIFO of pi1 commands with full/empty flags and occupancy.
// DEPTH must be a power of two so the pointers wrap naturally.
module pi1_cmdfifo
  import pi1_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter type T = pi1_cmd_t
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     push_i,
  input  T                         data_i,
  input  logic                     pop_i,
  output T                         data_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int unsigned PTRW = $clog2(DEPTH);
  localparam int unsigned CNTW = PTRW + 1;

  T                mem_q [DEPTH];
  logic [PTRW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTRW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNTW-1:0] count_q, count_d;
  logic            do_push, do_pop;

  always_comb begin
    full_o  = (count_q == CNTW'(DEPTH));
    empty_o = (count_q == '0);
    count_o = count_q;
    data_o  = mem_q[rd_ptr_q];
  end

  // Guarded handshakes: a simultaneous push and pop leaves the count unchanged.
  always_comb begin
    do_push  = push_i && !full_o;
    do_pop   = pop_i && !empty_o;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PTRW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + PTRW'(1);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CNTW'(1);
      2'b01:   count_d = count_q - CNTW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/pi1_initiator.sv
// PerInt master: queues bus commands and issues them one at a time onto a pi1 slave port.
// Optional watchdog enabled by defining PI1_INITIATOR_TIMEOUT_EN.
module pi1_initiator
  import pi1_pkg::*;
#(
  parameter  int unsigned ARCHBITSZ    = 16,
  parameter  int unsigned FIFODEPTH    = 4,
  parameter  int unsigned TIMEOUTBITSZ = 8,
  localparam int unsigned ADDRBITSZ    = pi1_addrbitsz(ARCHBITSZ),
  localparam int unsigned SELBITSZ     = ARCHBITSZ / 8
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 cmd_valid_i,
  output logic                 cmd_ready_o,
  input  logic [1:0]           cmd_op_i,
  input  logic [ADDRBITSZ-1:0] cmd_addr_i,
  input  logic [ARCHBITSZ-1:0] cmd_data_i,
  input  logic [SELBITSZ-1:0]  cmd_sel_i,
  output logic                 rsp_valid_o,
  input  logic                 rsp_ready_i,
  output logic [ARCHBITSZ-1:0] rsp_data_o,
  output logic                 rsp_err_o,
  output logic                 busy_o,
  output logic [1:0]           pi1_op_o,
  output logic [ADDRBITSZ-1:0] pi1_addr_o,
  output logic [ARCHBITSZ-1:0] pi1_data_o,
  output logic [SELBITSZ-1:0]  pi1_sel_o,
  input  logic [ARCHBITSZ-1:0] pi1_data_i,
  input  logic                 pi1_rdy_i
);

  if (FIFODEPTH < 2 || (FIFODEPTH & (FIFODEPTH - 1)) != 0 || TIMEOUTBITSZ == 0) begin : g_bad_params
    $error("pi1_initiator: FIFODEPTH must be a power of 2 >= 2 and TIMEOUTBITSZ >= 1");
  end

  typedef struct packed {
    logic [1:0]           op;
    logic [ADDRBITSZ-1:0] addr;
    logic [ARCHBITSZ-1:0] data;
    logic [SELBITSZ-1:0]  sel;
  } cmd_t;

  cmd_t                      push_cmd, head_cmd;
  logic                      fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [$clog2(FIFODEPTH):0] fifo_count;

  logic [1:0]           state_q, state_d;
  logic [1:0]           pi1_op_q, pi1_op_d;
  logic [ADDRBITSZ-1:0] pi1_addr_q, pi1_addr_d;
  logic [ARCHBITSZ-1:0] pi1_data_q, pi1_data_d;
  logic [SELBITSZ-1:0]  pi1_sel_q, pi1_sel_d;
  logic                 rsp_valid_q, rsp_valid_d;
  logic [ARCHBITSZ-1:0] rsp_data_q, rsp_data_d;

`ifdef PI1_INITIATOR_TIMEOUT_EN
  // The stall that brings the count to 2**TIMEOUTBITSZ-1 is the one that aborts.
  localparam logic [TIMEOUTBITSZ-1:0] TMO_LAST = {{(TIMEOUTBITSZ-1){1'b1}}, 1'b0};
  logic [TIMEOUTBITSZ-1:0] tmo_cnt_q, tmo_cnt_d;
  logic                    rsp_err_q, rsp_err_d;
`endif

  // PINOOP commands complete the handshake but are never queued.
  always_comb begin
    push_cmd.op   = cmd_op_i;
    push_cmd.addr = cmd_addr_i;
    push_cmd.data = cmd_data_i;
    push_cmd.sel  = cmd_sel_i;
    fifo_push     = cmd_valid_i && !fifo_full && (cmd_op_i != PINOOP);
  end

  pi1_cmdfifo #(
    .DEPTH (FIFODEPTH),
    .T     (cmd_t)
  ) u_cmdfifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (fifo_push),
    .data_i  (push_cmd),
    .pop_i   (fifo_pop),
    .data_o  (head_cmd),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  always_comb begin
    state_d     = state_q;
    pi1_op_d    = pi1_op_q;
    pi1_addr_d  = pi1_addr_q;
    pi1_data_d  = pi1_data_q;
    pi1_sel_d   = pi1_sel_q;
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    fifo_pop    = 1'b0;
`ifdef PI1_INITIATOR_TIMEOUT_EN
    tmo_cnt_d   = tmo_cnt_q;
    rsp_err_d   = rsp_err_q;
`endif

    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          fifo_pop   = 1'b1;
          pi1_op_d   = head_cmd.op;
          pi1_addr_d = head_cmd.addr;
          pi1_data_d = head_cmd.data;
          pi1_sel_d  = head_cmd.sel;
          state_d    = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (pi1_rdy_i) begin
          pi1_op_d = PINOOP;
          state_d  = (pi1_op_q == PIWROP) ? ST_IDLE : ST_WAITDATA;
        end
      end
      ST_WAITDATA: begin
        if (pi1_rdy_i) begin
          rsp_data_d  = pi1_data_i;
          rsp_valid_d = 1'b1;
          state_d     = ST_RESP;
        end
      end
      ST_RESP: begin
        if (rsp_ready_i) begin
          rsp_valid_d = 1'b0;
`ifdef PI1_INITIATOR_TIMEOUT_EN
          rsp_err_d   = 1'b0;
`endif
          state_d     = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

`ifdef PI1_INITIATOR_TIMEOUT_EN
    // Watchdog overrides the normal transition when the slave stalls too long.
    if ((state_q == ST_ISSUE || state_q == ST_WAITDATA) && !pi1_rdy_i) begin
      if (tmo_cnt_q == TMO_LAST) begin
        pi1_op_d    = PINOOP;
        rsp_data_d  = '0;
        rsp_valid_d = 1'b1;
        rsp_err_d   = 1'b1;
        state_d     = ST_RESP;
      end else begin
        tmo_cnt_d = tmo_cnt_q + TIMEOUTBITSZ'(1);
      end
    end else if (state_d != state_q) begin
      tmo_cnt_d = '0;
    end
`endif
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= ST_IDLE;
      pi1_op_q    <= PINOOP;
      pi1_addr_q  <= '0;
      pi1_data_q  <= '0;
      pi1_sel_q   <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      pi1_op_q    <= pi1_op_d;
      pi1_addr_q  <= pi1_addr_d;
      pi1_data_q  <= pi1_data_d;
      pi1_sel_q   <= pi1_sel_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
    end
  end

`ifdef PI1_INITIATOR_TIMEOUT_EN
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      tmo_cnt_q <= '0;
      rsp_err_q <= 1'b0;
    end else begin
      tmo_cnt_q <= tmo_cnt_d;
      rsp_err_q <= rsp_err_d;
    end
  end

  assign rsp_err_o = rsp_err_q;
`else
  assign rsp_err_o = 1'b0;
`endif

  assign cmd_ready_o = !fifo_full;
  assign busy_o      = (fifo_count != '0) || (state_q != ST_IDLE);
  assign pi1_op_o    = pi1_op_q;
  assign pi1_addr_o  = pi1_addr_q;
  assign pi1_data_o  = pi1_data_q;
  assign pi1_sel_o   = pi1_sel_q;
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_data_o  = rsp_data_q;

endmodule

// File: tb/tb_pi1_initiator.sv
// Bench for pi1_initiator against a small gpio-like slave model (IOCOUNT=8, inputs held at 0).
// The watchdog sequence runs only when PI1_INITIATOR_TIMEOUT_EN is defined.
module tb_pi1_initiator;
  import pi1_pkg::*;

  localparam int unsigned AW = 15;
  localparam logic [7:0]  GPIO_I = 8'h00;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid, cmd_ready;
  logic [1:0]  cmd_op;
  logic [AW-1:0] cmd_addr;
  logic [15:0] cmd_data;
  logic [1:0]  cmd_sel;
  logic        rsp_valid, rsp_ready, rsp_err, busy;
  logic [15:0] rsp_data;
  logic [1:0]  pi1_op;
  logic [AW-1:0] pi1_addr;
  logic [15:0] pi1_wdata, pi1_rdata;
  logic [1:0]  pi1_sel;
  logic        pi1_rdy;

  int checks = 0;
  int failures = 0;

  // Slave model state
  int          acc_cnt;
  logic [7:0]  gpio_o, gpio_t;
  logic [AW-1:0] acc_addr;
  logic [1:0]  acc_sel;

  always #5 clk = ~clk;

  pi1_initiator #(
    .ARCHBITSZ    (16),
    .FIFODEPTH    (4),
    .TIMEOUTBITSZ (4)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .cmd_valid_i (cmd_valid),
    .cmd_ready_o (cmd_ready),
    .cmd_op_i    (cmd_op),
    .cmd_addr_i  (cmd_addr),
    .cmd_data_i  (cmd_data),
    .cmd_sel_i   (cmd_sel),
    .rsp_valid_o (rsp_valid),
    .rsp_ready_i (rsp_ready),
    .rsp_data_o  (rsp_data),
    .rsp_err_o   (rsp_err),
    .busy_o      (busy),
    .pi1_op_o    (pi1_op),
    .pi1_addr_o  (pi1_addr),
    .pi1_data_o  (pi1_wdata),
    .pi1_sel_o   (pi1_sel),
    .pi1_data_i  (pi1_rdata),
    .pi1_rdy_i   (pi1_rdy)
  );

  // gpio-like slave: accepts on rdy, returns read data on the following cycle.
  always @(posedge clk) begin
    if (rst) begin
      acc_cnt   <= 0;
      gpio_o    <= 8'h00;
      gpio_t    <= 8'h00;
      acc_addr  <= '0;
      acc_sel   <= '0;
      pi1_rdata <= '0;
    end else if (pi1_op != PINOOP && pi1_rdy) begin
      acc_cnt  <= acc_cnt + 1;
      acc_addr <= pi1_addr;
      acc_sel  <= pi1_sel;
      case (pi1_op)
        PIWROP: begin gpio_o <= pi1_wdata[7:0]; pi1_rdata <= 16'h0000; end
        PIRDOP: pi1_rdata <= {8'h00, GPIO_I};
        default: begin gpio_t <= pi1_wdata[7:0]; pi1_rdata <= 16'd8; end
      endcase
    end
  end

  typedef struct {
    logic [1:0]    op;
    logic [AW-1:0] addr;
    logic [15:0]   data;
    logic [1:0]    sel;
    bit            exp_rsp;
    logic [15:0]   exp_data;
    logic [7:0]    exp_o;
    logic [7:0]    exp_t;
  } vec_t;

  vec_t vecs [6];

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  task automatic push(input logic [1:0] op, input logic [AW-1:0] addr,
                      input logic [15:0] data, input logic [1:0] sel);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_addr  = addr;
    cmd_data  = data;
    cmd_sel   = sel;
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic wait_rsp(input string name);
    int n = 0;
    while (!rsp_valid && n < 100) begin
      tick();
      n++;
    end
    if (!rsp_valid) check({name, "_rsp_timeout"}, 32'(rsp_valid), 32'd1);
  endtask

  task automatic consume(input string name);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    check({name, "_rsp_cleared"}, 32'(rsp_valid), 32'd0);
  endtask

  task automatic wait_op(input logic [1:0] op, input string name);
    int n = 0;
    while (pi1_op != op && n < 20) begin
      tick();
      n++;
    end
    if (pi1_op != op) check({name, "_op_timeout"}, 32'(pi1_op), 32'(op));
  endtask

  initial begin
    int   base;
    int   n;
    bit   seen;
    bit   stable;
    logic [15:0] fexp [5];
    logic [1:0]  fop  [5];

    vecs[0] = '{PIRWOP, 15'h0010, 16'h00F0, 2'b01, 1'b1, 16'h0008, 8'h00, 8'hF0};
    vecs[1] = '{PIWROP, 15'h0011, 16'h00A5, 2'b01, 1'b0, 16'h0000, 8'hA5, 8'hF0};
    vecs[2] = '{PIRDOP, 15'h0012, 16'h0000, 2'b11, 1'b1, 16'h0000, 8'hA5, 8'hF0};
    vecs[3] = '{PIWROP, 15'h7FFF, 16'h003C, 2'b10, 1'b0, 16'h0000, 8'h3C, 8'hF0};
    vecs[4] = '{PIRWOP, 15'h0000, 16'h000F, 2'b11, 1'b1, 16'h0008, 8'h3C, 8'h0F};
    vecs[5] = '{PIRDOP, 15'h1234, 16'hFFFF, 2'b01, 1'b1, 16'h0000, 8'h3C, 8'h0F};

    rst = 1'b1; cmd_valid = 1'b0; cmd_op = PINOOP; cmd_addr = '0; cmd_data = '0;
    cmd_sel = '0; rsp_ready = 1'b0; pi1_rdy = 1'b1;
    repeat (3) tick();
    check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    check("rst_busy",      32'(busy),      32'd0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp_data",  32'(rsp_data),  32'd0);
    check("rst_rsp_err",   32'(rsp_err),   32'd0);
    check("rst_pi1_op",    32'(pi1_op),    32'd0);
    check("rst_pi1_data",  32'(pi1_wdata), 32'd0);
    rst = 1'b0;
    tick();

    // Issue latency: op appears two cycles after the push
    push(PIRDOP, 15'h0001, 16'h0000, 2'b11);
    check("lat_cycle1_noop", 32'(pi1_op), 32'(PINOOP));
    check("lat_busy", 32'(busy), 32'd1);
    tick();
    check("lat_cycle2_op", 32'(pi1_op), 32'(PIRDOP));
    check("lat_cycle2_addr", 32'(pi1_addr), 32'h0001);
    wait_rsp("lat");
    check("lat_rsp_data", 32'(rsp_data), 32'h0000);
    consume("lat");

    // PINOOP pushes are dropped
    base = acc_cnt;
    push(PINOOP, 15'h0005, 16'h1111, 2'b11);
    check("noop_not_busy", 32'(busy), 32'd0);
    repeat (3) tick();
    check("noop_no_accept", 32'(acc_cnt - base), 32'd0);

    for (int i = 0; i < 6; i++) begin
      string nm;
      nm = $sformatf("vec%0d", i);
      push(vecs[i].op, vecs[i].addr, vecs[i].data, vecs[i].sel);
      if (vecs[i].exp_rsp) begin
        wait_rsp(nm);
        check({nm, "_rsp_data"}, 32'(rsp_data), 32'(vecs[i].exp_data));
        check({nm, "_rsp_err"},  32'(rsp_err),  32'd0);
        consume(nm);
      end else begin
        seen = 1'b0;
        n = 0;
        while (busy && n < 100) begin
          if (rsp_valid) seen = 1'b1;
          tick();
          n++;
        end
        check({nm, "_no_rsp"}, 32'(seen | rsp_valid), 32'd0);
        check({nm, "_idle"},   32'(busy), 32'd0);
      end
      tick();
      check({nm, "_gpio_o"},   32'(gpio_o),   32'(vecs[i].exp_o));
      check({nm, "_gpio_t"},   32'(gpio_t),   32'(vecs[i].exp_t));
      check({nm, "_acc_addr"}, 32'(acc_addr), 32'(vecs[i].addr));
      check({nm, "_acc_sel"},  32'(acc_sel),  32'(vecs[i].sel));
    end

    // FIFO full with responses held off, then in-order drain
    fop[0] = PIRWOP; fexp[0] = 16'h0008;
    fop[1] = PIRDOP; fexp[1] = 16'h0000;
    fop[2] = PIRWOP; fexp[2] = 16'h0008;
    fop[3] = PIRDOP; fexp[3] = 16'h0000;
    fop[4] = PIRWOP; fexp[4] = 16'h0008;
    rsp_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      check($sformatf("fill%0d_ready", k), 32'(cmd_ready), 32'd1);
      push(fop[k], AW'(16 + k), 16'(8'h20 + k), 2'b11);
    end
    check("fill_full_ready", 32'(cmd_ready), 32'd0);
    repeat (5) tick();
    check("fill_still_full", 32'(cmd_ready), 32'd0);
    check("fill_rsp_pending", 32'(rsp_valid), 32'd1);
    for (int k = 0; k < 5; k++) begin
      wait_rsp($sformatf("drain%0d", k));
      check($sformatf("drain%0d_data", k), 32'(rsp_data), 32'(fexp[k]));
      consume($sformatf("drain%0d", k));
    end
    tick();
    check("drain_ready", 32'(cmd_ready), 32'd1);
    check("drain_idle",  32'(busy),      32'd0);
    check("drain_gpio_t", 32'(gpio_t),   32'h24);

    // Slave stall during ISSUE: op held, accepted exactly once
    pi1_rdy = 1'b0;
    push(PIWROP, 15'h0033, 16'h0055, 2'b01);
    wait_op(PIWROP, "stall");
    base = acc_cnt;
    stable = 1'b1;
    repeat (10) begin
      tick();
      if (pi1_op != PIWROP || pi1_wdata != 16'h0055 || pi1_addr != 15'h0033) stable = 1'b0;
    end
    check("stall_held_stable", 32'(stable), 32'd1);
    pi1_rdy = 1'b1;
    tick();
    check("stall_op_dropped", 32'(pi1_op), 32'(PINOOP));
    check("stall_one_accept", 32'(acc_cnt - base), 32'd1);
    repeat (3) tick();
    check("stall_no_dup", 32'(acc_cnt - base), 32'd1);
    check("stall_gpio_o", 32'(gpio_o), 32'h55);

`ifdef PI1_INITIATOR_TIMEOUT_EN
    // Watchdog: 15 stall cycles abort with an error response
    pi1_rdy = 1'b0;
    base = acc_cnt;
    push(PIRDOP, 15'h0040, 16'h0000, 2'b11);
    wait_op(PIRDOP, "tmo");
    n = 0;
    while (!rsp_valid && n < 40) begin
      tick();
      n++;
    end
    check("tmo_stall_cycles", 32'(n), 32'd15);
    check("tmo_err",  32'(rsp_err),  32'd1);
    check("tmo_data", 32'(rsp_data), 32'd0);
    check("tmo_op_noop", 32'(pi1_op), 32'(PINOOP));
    consume("tmo");
    check("tmo_err_cleared", 32'(rsp_err), 32'd0);
    check("tmo_no_accept", 32'(acc_cnt - base), 32'd0);
    pi1_rdy = 1'b1;
    tick();
`endif

    // Reset while in WAITDATA with two commands queued
    pi1_rdy = 1'b0;
    push(PIRDOP, 15'h0050, 16'h0000, 2'b11);
    push(PIRDOP, 15'h0051, 16'h0000, 2'b11);
    push(PIRDOP, 15'h0052, 16'h0000, 2'b11);
    check("rstw_issue_op", 32'(pi1_op), 32'(PIRDOP));
    pi1_rdy = 1'b1;
    tick();
    pi1_rdy = 1'b0;
    check("rstw_waitdata_noop", 32'(pi1_op), 32'(PINOOP));
    check("rstw_busy_before", 32'(busy), 32'd1);
    rst = 1'b1;
    tick();
    check("rstw_pi1_op",    32'(pi1_op),    32'(PINOOP));
    check("rstw_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rstw_busy",      32'(busy),      32'd0);
    check("rstw_cmd_ready", 32'(cmd_ready), 32'd1);
    rst = 1'b0;
    pi1_rdy = 1'b1;
    repeat (5) tick();
    check("rstw_queue_dropped", 32'(busy), 32'd0);
    check("rstw_no_new_op", 32'(acc_cnt), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
